// File: rtl/host_monitor_if.sv
// Memory-mapped bus between a master (CPU) and the host_monitor slave.
// The master holds a request stable until it sees mem_ready.
interface host_monitor_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/host_monitor.sv
// Host/console device: exit-code capture, console byte FIFO and watchdog,
// exposed as a 16-byte register window on the data bus.
module host_monitor #(
    parameter logic [31:0] BASE_ADDR  = 32'h0010_0000,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    host_monitor_if.slave        bus,
    output logic                 char_valid,
    output logic [7:0]           char_data,
    input  logic                 char_ready,
    output logic                 host_done,
    output logic [31:0]          host_exit,
    output logic                 host_timeout
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] REG_TOHOST  = 2'd0;
    localparam logic [1:0] REG_PRINT   = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_MAXTIME = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESP  = 2'd1,
        STALL = 2'd2
    } state_e;

    state_e               state_q, state_d;

    logic                 req_hit_q, req_hit_d;
    logic [1:0]           req_reg_q, req_reg_d;
    logic                 req_instr_q, req_instr_d;
    logic [3:0]           req_wstrb_q, req_wstrb_d;
    logic [31:0]          req_wdata_q, req_wdata_d;

    logic                 mem_ready_q, mem_ready_d;
    logic [31:0]          mem_rdata_q, mem_rdata_d;

    logic [7:0]           fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     fifo_cnt_q, fifo_cnt_d;
    logic                 char_valid_q, char_valid_d;
    logic [7:0]           char_data_q, char_data_d;

    logic                 host_done_q, host_done_d;
    logic [31:0]          host_exit_q, host_exit_d;
    logic                 host_timeout_q, host_timeout_d;
    logic [CNT_WIDTH-1:0] maxtime_q, maxtime_d;
    logic [CNT_WIDTH-1:0] wd_cnt_q, wd_cnt_d;

    logic                 bus_hit_c;
    logic [1:0]           bus_reg_c;
    logic                 bus_push_c;
    logic [31:0]          rd_val_c;
    logic                 fifo_full_c;
    logic                 fifo_empty_c;
    logic                 pop_c;
    logic                 push_c;
    logic                 req_wr_c;
    logic                 unused_c;

    // Decode of the request currently on the bus (used only while IDLE)
    assign bus_hit_c    = (bus.mem_addr[31:4] == BASE_ADDR[31:4]);
    assign bus_reg_c    = bus.mem_addr[3:2];
    assign bus_push_c   = bus_hit_c && !bus.mem_instr && (bus_reg_c == REG_PRINT)
                          && bus.mem_wstrb[0];
    assign unused_c     = ^bus.mem_addr[1:0];

    assign fifo_full_c  = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty_c = (fifo_cnt_q == '0);
    assign pop_c        = char_valid_q && char_ready;

    // Side effects of the latched request are applied at the end of the ready cycle
    assign req_wr_c     = (state_q == RESP) && req_hit_q && !req_instr_q && (req_wstrb_q != 4'b0);
    assign push_c       = req_wr_c && (req_reg_q == REG_PRINT) && req_wstrb_q[0]
                          && (!fifo_full_c || pop_c);

    // Read data for the request being accepted; fetches and writes return 0
    always_comb begin
        rd_val_c = '0;
        if (bus_hit_c && !bus.mem_instr && (bus.mem_wstrb == 4'b0)) begin
            case (bus_reg_c)
                REG_TOHOST:  rd_val_c = host_exit_q;
                REG_PRINT:   rd_val_c = 32'(fifo_cnt_q);
                REG_STATUS:  rd_val_c = {28'b0, host_timeout_q, host_done_q,
                                         fifo_full_c, fifo_empty_c};
                REG_MAXTIME: rd_val_c = 32'(maxtime_q);
                default:     rd_val_c = '0;
            endcase
        end
    end

    // Bus handshake FSM
    always_comb begin
        state_d     = state_q;
        req_hit_d   = req_hit_q;
        req_reg_d   = req_reg_q;
        req_instr_d = req_instr_q;
        req_wstrb_d = req_wstrb_q;
        req_wdata_d = req_wdata_q;
        mem_ready_d = 1'b0;
        mem_rdata_d = '0;

        case (state_q)
            IDLE: begin
                if (bus.mem_valid) begin
                    req_hit_d   = bus_hit_c;
                    req_reg_d   = bus_reg_c;
                    req_instr_d = bus.mem_instr;
                    req_wstrb_d = bus.mem_wstrb;
                    req_wdata_d = bus.mem_wdata;
                    if (bus_push_c && fifo_full_c && !pop_c) begin
                        state_d = STALL;
                    end else begin
                        state_d     = RESP;
                        mem_ready_d = 1'b1;
                        mem_rdata_d = rd_val_c;
                    end
                end
            end
            STALL: begin
                if (!fifo_full_c || pop_c) begin
                    state_d     = RESP;
                    mem_ready_d = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Console FIFO pointers, occupancy and registered head
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_cnt_d   = fifo_cnt_q;
        char_data_d  = char_data_q;

        if (push_c) begin
            wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
        end
        if (pop_c) begin
            rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
        end
        case ({push_c, pop_c})
            2'b10:   fifo_cnt_d = CNT_W'(fifo_cnt_q + 1'b1);
            2'b01:   fifo_cnt_d = CNT_W'(fifo_cnt_q - 1'b1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        char_valid_d = (fifo_cnt_d != '0);
        // The new head is the byte being written when the read pointer lands on the write slot
        if (char_valid_d) begin
            if (push_c && (rd_ptr_d == wr_ptr_q)) begin
                char_data_d = req_wdata_q[7:0];
            end else begin
                char_data_d = fifo_mem_q[rd_ptr_d];
            end
        end
    end

    // Exit code capture, MAXTIME register and watchdog
    always_comb begin
        host_done_d    = host_done_q;
        host_exit_d    = host_exit_q;
        host_timeout_d = host_timeout_q;
        maxtime_d      = maxtime_q;
        wd_cnt_d       = wd_cnt_q;

        if (req_wr_c && (req_reg_q == REG_TOHOST) && (req_wdata_q != '0) && !host_done_q) begin
            host_done_d = 1'b1;
            host_exit_d = req_wdata_q;
        end

        if (req_wr_c && (req_reg_q == REG_MAXTIME)) begin
            maxtime_d = CNT_WIDTH'(req_wdata_q);
            wd_cnt_d  = '0;
        end else if ((maxtime_q != '0) && !host_done_q && !host_timeout_q
                     && (wd_cnt_q != '1)) begin
            wd_cnt_d = CNT_WIDTH'(wd_cnt_q + 1'b1);
            if (wd_cnt_q == CNT_WIDTH'(maxtime_q - 1'b1)) begin
                host_timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            req_hit_q      <= 1'b0;
            req_reg_q      <= '0;
            req_instr_q    <= 1'b0;
            req_wstrb_q    <= '0;
            req_wdata_q    <= '0;
            mem_ready_q    <= 1'b0;
            mem_rdata_q    <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fifo_cnt_q     <= '0;
            char_valid_q   <= 1'b0;
            char_data_q    <= '0;
            host_done_q    <= 1'b0;
            host_exit_q    <= '0;
            host_timeout_q <= 1'b0;
            maxtime_q      <= '0;
            wd_cnt_q       <= '0;
        end else begin
            state_q        <= state_d;
            req_hit_q      <= req_hit_d;
            req_reg_q      <= req_reg_d;
            req_instr_q    <= req_instr_d;
            req_wstrb_q    <= req_wstrb_d;
            req_wdata_q    <= req_wdata_d;
            mem_ready_q    <= mem_ready_d;
            mem_rdata_q    <= mem_rdata_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fifo_cnt_q     <= fifo_cnt_d;
            char_valid_q   <= char_valid_d;
            char_data_q    <= char_data_d;
            host_done_q    <= host_done_d;
            host_exit_q    <= host_exit_d;
            host_timeout_q <= host_timeout_d;
            maxtime_q      <= maxtime_d;
            wd_cnt_q       <= wd_cnt_d;
        end
    end

    // FIFO storage carries data only, so it needs no reset
    always_ff @(posedge clock) begin
        if (push_c) begin
            fifo_mem_q[wr_ptr_q] <= req_wdata_q[7:0];
        end
    end

    assign bus.mem_ready = mem_ready_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign char_valid    = char_valid_q;
    assign char_data     = char_data_q;
    assign host_done     = host_done_q;
    assign host_exit     = host_exit_q;
    assign host_timeout  = host_timeout_q;

endmodule
